// File: rtl/load_ext_pkg.sv
// load_ext_pkg: shared types for the load-extension pipeline.
//   size_e  : encoding of the in_size request field
//   state_e : occupancy of the two-entry output buffer
package load_ext_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/ext_align.sv
// ext_align: combinational load alignment. Extracts a byte/half/word from a
// memory word at a byte offset, sign- or zero-extends it, and flags illegal
// requests (result forced to zero).
//   in_data/in_off/in_size/in_unsigned : raw request
//   res_data : extended result, res_err : request was illegal
module ext_align
  import load_ext_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int OFF_WIDTH  = $clog2(DATA_WIDTH/8)
) (
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [OFF_WIDTH-1:0]  in_off,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err
);

  // Highest offset at which a full halfword still fits inside the word.
  localparam logic [OFF_WIDTH-1:0] HALF_MAX = OFF_WIDTH'(DATA_WIDTH/8 - 2);

  logic [7:0]  byte_f;
  logic [15:0] half_f;

  always_comb begin
    // Truncating casts keep only the low field of the shifted word.
    byte_f   = 8'(in_data >> {in_off, 3'b000});
    half_f   = 16'(in_data >> {in_off, 3'b000});
    res_data = '0;
    res_err  = 1'b0;
    case (size_e'(in_size))
      SZ_BYTE: res_data = {{(DATA_WIDTH-8){~in_unsigned & byte_f[7]}}, byte_f};
      SZ_HALF: begin
        if (in_off[0] || (in_off > HALF_MAX)) res_err = 1'b1;
        else res_data = {{(DATA_WIDTH-16){~in_unsigned & half_f[15]}}, half_f};
      end
      SZ_WORD: begin
        if (in_off != '0) res_err = 1'b1;
        else res_data = in_data;
      end
      default: res_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_ext_pipe.sv
// load_ext_pipe: one-cycle load extension stage with a two-entry elastic
// buffer (output register + skid register) and a saturating error counter.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : request handshake; in_ready is purely registered
//   in_data/in_off/in_size/in_unsigned : request fields
//   out_valid/out_ready  : result handshake
//   out_data/out_err     : extended result, illegal-request flag
//   err_count            : saturating count of accepted illegal requests
module load_ext_pipe
  import load_ext_pkg::*;
#(
  parameter  int DATA_WIDTH    = 32,
  parameter  int ERR_CNT_WIDTH = 8,
  localparam int OFF_WIDTH     = $clog2(DATA_WIDTH/8)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [OFF_WIDTH-1:0]     in_off,
  input  logic [1:0]               in_size,
  input  logic                     in_unsigned,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

  logic [DATA_WIDTH-1:0]    a_data;
  logic                     a_err;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     out_err_q, out_err_d;
  logic [DATA_WIDTH-1:0]    skid_data_q, skid_data_d;
  logic                     skid_err_q, skid_err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     acc, cons;

  ext_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .in_data     (in_data),
    .in_off      (in_off),
    .in_size     (in_size),
    .in_unsigned (in_unsigned),
    .res_data    (a_data),
    .res_err     (a_err)
  );

  // Both handshake flags decode straight from the state flop, so in_ready
  // never depends combinationally on out_ready.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign err_count = err_cnt_q;

  always_comb begin
    acc         = in_valid & in_ready;
    cons        = out_valid & out_ready;
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    err_cnt_d   = err_cnt_q;

    // Counted at acceptance, independent of when the result drains.
    if (acc && a_err && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + 1'b1;

    case (state_q)
      EMPTY: if (acc) begin
        out_data_d = a_data;
        out_err_d  = a_err;
        state_d    = ONE;
      end
      ONE: begin
        if (acc && cons) begin
          out_data_d = a_data;
          out_err_d  = a_err;
        end else if (acc) begin
          skid_data_d = a_data;
          skid_err_d  = a_err;
          state_d     = FULL;
        end else if (cons) begin
          state_d = EMPTY;
        end
      end
      FULL: if (cons) begin
        out_data_d = skid_data_q;
        out_err_d  = skid_err_q;
        state_d    = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_load_ext_pipe.sv
// tb_load_ext_pipe: directed + randomized bench for load_ext_pipe. A queue
// model tracks buffered results; expected values come from arithmetic on the
// request fields. Extra instances cover ERR_CNT_WIDTH=2 and DATA_WIDTH=64.
module tb_load_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_unsigned, out_ready;
  logic [31:0] in_data;
  logic [1:0]  in_off, in_size;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_data;
  logic [7:0]  err_count;

  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_data2;
  logic [1:0]  err_count2;

  logic        v64, uns64, ordy64, rdy64, ov64, oerr64;
  logic [63:0] d64, od64;
  logic [2:0]  off64;
  logic [1:0]  sz64;
  logic [7:0]  ec64;

  always #5 clk = ~clk;

  load_ext_pipe #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_off(in_off), .in_size(in_size),
    .in_unsigned(in_unsigned), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .err_count(err_count));

  load_ext_pipe #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_off(in_off), .in_size(in_size),
    .in_unsigned(in_unsigned), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_err(out_err2), .err_count(err_count2));

  load_ext_pipe #(.DATA_WIDTH(64), .ERR_CNT_WIDTH(8)) dut64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_ready(rdy64),
    .in_data(d64), .in_off(off64), .in_size(sz64),
    .in_unsigned(uns64), .out_valid(ov64), .out_ready(ordy64),
    .out_data(od64), .out_err(oerr64), .err_count(ec64));

  typedef struct { logic [63:0] d; bit e; } rec_t;

  rec_t q[$];
  int   errs, errs2;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: field = (data / 256^off) mod 2^w, negative values wrap to the
  // two's-complement pattern of the full word.
  function automatic rec_t ref_ext(logic [63:0] data, int off, int sz, bit uns, int nb);
    rec_t r;
    longint unsigned v, m;
    int w;
    bit ill;
    ill = (sz == 3) || (sz == 2 && off != 0) || (sz == 1 && ((off % 2) == 1 || off > nb - 2));
    m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8*nb)) - 1);
    r.e = ill;
    if (ill) v = 0;
    else if (sz == 2) v = data;
    else begin
      w = (sz == 0) ? 8 : 16;
      v = (data >> (8*off)) % (64'd1 << w);
      if (!uns && v >= (64'd1 << (w-1))) v = v - (64'd1 << w);
    end
    r.d = v & m;
    return r;
  endfunction

  // One clock of the 32-bit pair: check against the model before the edge,
  // then advance the model by what the edge will do.
  task automatic step();
    bit acc, cons;
    rec_t r;
    @(negedge clk);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("in_ready_w2", in_ready2, q.size() < 2);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_err", out_err, q[0].e);
      chk("out_data_w2", out_data2, q[0].d);
    end
    chk("err_count", err_count, errs);
    chk("err_count_w2", err_count2, errs2);
    if (reset) begin
      q.delete();
      errs = 0;
      errs2 = 0;
    end else begin
      acc  = in_valid && (q.size() < 2);
      cons = out_ready && (q.size() > 0);
      if (cons) void'(q.pop_front());
      if (acc) begin
        r = ref_ext(64'(in_data), int'(in_off), int'(in_size), in_unsigned, 4);
        q.push_back(r);
        if (r.e) begin
          if (errs < 255) errs++;
          if (errs2 < 3) errs2++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] o, input logic [1:0] s, input logic u);
    in_valid = 1'b1; in_data = d; in_off = o; in_size = s; in_unsigned = u;
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_data = 0; in_off = 0; in_size = 0;
    in_unsigned = 0; out_ready = 1;
    v64 = 0; d64 = 0; off64 = 0; sz64 = 0; uns64 = 0; ordy64 = 1;
    errs = 0; errs2 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);

    // Signed byte
    drive(32'h1234_5680, 2'd0, 2'b00, 1'b0); step();
    chk("sbyte_data", out_data, 32'hFFFF_FF80);
    chk("sbyte_err", out_err, 0);
    // Half at offset 2, unsigned then signed
    drive(32'h8001_ABCD, 2'd2, 2'b01, 1'b1); step();
    chk("uhalf_data", out_data, 32'h0000_8001);
    drive(32'h8001_ABCD, 2'd2, 2'b01, 1'b0); step();
    chk("shalf_data", out_data, 32'hFFFF_8001);
    // Illegal requests
    drive(32'hFFFF_FFFF, 2'd1, 2'b01, 1'b0); step();
    chk("ill_data", out_data, 0);
    chk("ill_err", out_err, 1);
    chk("ill_cnt", err_count, 1);
    drive(32'h1111_1111, 2'd0, 2'b11, 1'b0); step();
    drive(32'h2222_2222, 2'd2, 2'b10, 1'b0); step();
    drive(32'h3333_3333, 2'd3, 2'b01, 1'b1); step();
    drive(32'h4444_4444, 2'd1, 2'b01, 1'b1); step();
    in_valid = 0; step();
    chk("ill_cnt5", err_count, 5);
    chk("ill_cnt_sat", err_count2, 3);

    // Backpressure: A, B fill the buffer, C waits
    out_ready = 0;
    drive(32'h0000_AA00, 2'd1, 2'b00, 1'b1); step();
    drive(32'h0000_8765, 2'd0, 2'b01, 1'b0); step();
    chk("bp_full_ready", in_ready, 0);
    drive(32'hDEAD_BEEF, 2'd0, 2'b10, 1'b0); step();
    chk("bp_hold_a", out_data, 32'h0000_00AA);
    step();
    chk("bp_hold_a2", out_data, 32'h0000_00AA);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1; step();
    chk("bp_b", out_data, 32'hFFFF_8765);
    step();
    chk("bp_c", out_data, 32'hDEAD_BEEF);
    in_valid = 0; step();
    chk("bp_drained", out_valid, 0);

    // Reset while FULL, with a request on the reset edge
    out_ready = 0;
    drive(32'h5555_5555, 2'd0, 2'b11, 1'b0); step();
    drive(32'h0000_0077, 2'd0, 2'b00, 1'b0); step();
    reset = 1; drive(32'h0000_0066, 2'd0, 2'b00, 1'b0); step();
    reset = 0; in_valid = 0;
    chk("rstf_out_valid", out_valid, 0);
    chk("rstf_err_count", err_count, 0);
    chk("rstf_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (3) step();

    // 64-bit instance
    v64 = 1; d64 = 64'h8000_0000_0000_0000; off64 = 3'd7; sz64 = 2'b00; uns64 = 0;
    @(posedge clk); #1;
    chk("w64_byte7", od64, 64'hFFFF_FFFF_FFFF_FF80);
    chk("w64_byte7_err", oerr64, 0);
    d64 = 64'hABCD_0000_0000_0000; off64 = 3'd6; sz64 = 2'b01; uns64 = 1;
    @(posedge clk); #1;
    chk("w64_half6", od64, 64'h0000_0000_0000_ABCD);
    d64 = 64'h1234_5678_9ABC_DEF0; off64 = 3'd4; sz64 = 2'b10;
    @(posedge clk); #1;
    chk("w64_word4_err", oerr64, 1);
    chk("w64_word4_data", od64, 0);
    chk("w64_err_count", ec64, 1);
    v64 = 0;

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = $urandom;
      in_off      = 2'($urandom_range(0, 3));
      in_size     = 2'($urandom_range(0, 3));
      in_unsigned = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 0; out_ready = 1;
    repeat (3) step();
    chk("final_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_ext_pipe.md
LOAD_EXT_PIPE -- requirements
Module: load_ext_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; legal values are multiples of 8 and at least 16.
REQ-002 SHALL have parameter ERR_CNT_WIDTH, default 8: width of the saturating error counter.
REQ-003 SHALL derive localparam OFF_WIDTH = $clog2(DATA_WIDTH/8).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports ordered as follows:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  module can accept a request
- in_data  input  DATA_WIDTH  raw memory word
- in_off  input  OFF_WIDTH  byte offset within the word
- in_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- in_unsigned  input  1  1 = zero-extend, 0 = sign-extend
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  DATA_WIDTH  extended result
- out_err  output  1  result came from an illegal request
- err_count  output  ERR_CNT_WIDTH  saturating count of accepted illegal requests

Function
REQ-005 Extraction: byte = in_data[8*off +: 8]; half = in_data[8*off +: 16]; word = in_data unchanged.
REQ-006 Extension: the extracted field fills the upper bits with its MSB when in_unsigned=0, and with zeros when in_unsigned=1; word size ignores in_unsigned.
REQ-007 Illegal request: half with off[0]=1, half with off > DATA_WIDTH/8-2, word with off≠0, or size 11.
- out_data = 0 and out_err = 1.
REQ-008 A request is accepted when in_valid && in_ready on a rising clk edge.
REQ-009 Latency: an accepted request appears on out_data/out_err with out_valid=1 on the next cycle when the output is free.
REQ-010 A result is consumed when out_valid && out_ready.
REQ-011 While out_valid=1 && out_ready=0, out_data and out_err SHALL hold stable.
REQ-012 Buffering: a two-entry buffer, made of the output register plus one skid register.
- in_ready = ~skid_valid, which is a registered signal with no combinational path from out_ready.
REQ-013 States SHALL be EMPTY, ONE and FULL:
- EMPTY: accept goes to ONE.
- ONE: accept and consume stays ONE, with the new result in the output register.
- ONE: accept without consume goes to FULL, with the new result in the skid register.
- ONE: consume without accept goes to EMPTY.
- FULL: consume moves skid to output and goes to ONE; accept is impossible (in_ready=0).
REQ-014 Ordering: results leave in acceptance order, with no loss or duplication.
REQ-015 err_count increments by 1 per accepted illegal request and saturates at 2^ERR_CNT_WIDTH-1; there is no wrap.
REQ-016 err_count updates on the acceptance edge, not on the consume edge.

Reset
REQ-017 Reset values: out_valid=0, skid_valid=0, out_data=0, out_err=0, err_count=0, in_ready=1 on the cycle after reset.
REQ-018 Reset mid-operation discards all buffered results, with no partial output.
REQ-019 If reset and in_valid are high on the same edge, reset SHALL win and the request is dropped.

Structure
REQ-020 Package load_ext_pkg SHALL hold:
- the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
- the state enum (EMPTY, ONE, FULL).
REQ-021 Sub-module ext_align SHALL be combinational: it performs extraction, extension and illegal detection, parametrised by DATA_WIDTH, and is instantiated once at the input side.
REQ-022 The top level SHALL hold only the buffer, the state logic and the counter.

Verification
REQ-023 The bench SHALL cover the sign byte case: data=0x12345680, off=0, byte, signed -> next cycle out_data=0xFFFFFF80, out_err=0.
REQ-024 The bench SHALL cover the zero half case: data=0x8001ABCD, off=2, half, unsigned -> out_data=0x00008001; off=2, signed -> 0xFFFF8001.
REQ-025 The bench SHALL cover the illegal case: half with off=1 -> out_data=0, out_err=1, err_count 0→1; with ERR_CNT_WIDTH=2, five illegal requests -> err_count=3.
REQ-026 The bench SHALL cover backpressure:
- Stimulus: out_ready=0 with three back-to-back valid requests A, B, C.
- Response: A and B are accepted; in_ready=0 after B; C is held.
- Stimulus: raise out_ready.
- Response: A, B and C emerge in order, one per cycle, with data held stable while stalled.
REQ-027 The bench SHALL cover reset in FULL: reset asserted for one cycle -> out_valid=0, err_count=0, in_ready=1, and no stale A or B appears afterwards.
REQ-028 The bench SHALL cover DATA_WIDTH=64: byte at off=7 of 0x80000000_00000000, signed -> 0xFFFFFFFF_FFFFFF80; word at off=4 -> out_err=1.
